alu_exec_sequencer: RTL and testbench

//  Multi-cycle execute stage wrapped around the combinational ALU. Accepts one
//  R/I-type command, reads the operands from the register file, drives the ALU,

---
 rtl/alu_exec_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_alu_exec_sequencer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_sequencer.sv
// Multi-cycle execute stage: fetches operands from the register file, drives the
// combinational ALU, captures its result and writes it back (IDLE->FETCH->EXEC->WB).
module alu_exec_sequencer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned OPRN_WIDTH = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  CMD_VALID,
  output logic                  CMD_READY,
  input  logic [OPRN_WIDTH-1:0] CMD_OPRN,
  input  logic [ADDR_WIDTH-1:0] CMD_RS,
  input  logic [ADDR_WIDTH-1:0] CMD_RT,
  input  logic [ADDR_WIDTH-1:0] CMD_RD,
  input  logic                  CMD_IMM_SEL,
  input  logic [15:0]           CMD_IMM,
  output logic                  RF_READ,
  output logic [ADDR_WIDTH-1:0] RF_ADDR_R1,
  output logic [ADDR_WIDTH-1:0] RF_ADDR_R2,
  input  logic [DATA_WIDTH-1:0] RF_DATA_R1,
  input  logic [DATA_WIDTH-1:0] RF_DATA_R2,
  output logic                  RF_WRITE,
  output logic [ADDR_WIDTH-1:0] RF_ADDR_W,
  output logic [DATA_WIDTH-1:0] RF_DATA_W,
  output logic [DATA_WIDTH-1:0] ALU_OP1,
  output logic [DATA_WIDTH-1:0] ALU_OP2,
  output logic [OPRN_WIDTH-1:0] ALU_OPRN,
  input  logic [DATA_WIDTH-1:0] ALU_OUT,
  input  logic                  ALU_ZERO,
  output logic                  DONE,
  output logic [DATA_WIDTH-1:0] RESULT,
  output logic                  ZERO_FLAG,
  output logic                  ERR
);

  localparam int unsigned IMM_WIDTH = 16;
  localparam int unsigned OPRN_MAX  = 9;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_WB    = 2'd3
  } state_t;

  typedef struct packed {
    logic [OPRN_WIDTH-1:0] oprn;
    logic [ADDR_WIDTH-1:0] rd;
    logic                  imm_sel;
    logic [IMM_WIDTH-1:0]  imm;
  } cmd_t;

  state_t                state_q, state_d;
  cmd_t                  cmd_q, cmd_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  rf_read_q, rf_read_d;
  logic [ADDR_WIDTH-1:0] rf_addr_r1_q, rf_addr_r1_d;
  logic [ADDR_WIDTH-1:0] rf_addr_r2_q, rf_addr_r2_d;
  logic                  rf_write_q, rf_write_d;
  logic [ADDR_WIDTH-1:0] rf_addr_w_q, rf_addr_w_d;
  logic [DATA_WIDTH-1:0] rf_data_w_q, rf_data_w_d;
  logic [DATA_WIDTH-1:0] alu_op1_q, alu_op1_d;
  logic [DATA_WIDTH-1:0] alu_op2_q, alu_op2_d;
  logic [OPRN_WIDTH-1:0] alu_oprn_q, alu_oprn_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  zero_flag_q, zero_flag_d;
  logic                  err_q, err_d;
  logic                  illegal_c;
  logic [DATA_WIDTH-1:0] imm_ext_c;

  assign illegal_c = (cmd_q.oprn == '0) || (cmd_q.oprn > OPRN_WIDTH'(OPRN_MAX));
  assign imm_ext_c = DATA_WIDTH'($signed(cmd_q.imm));

  // Next state and next values of every registered output
  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    cmd_ready_d  = 1'b0;
    rf_read_d    = 1'b0;
    rf_addr_r1_d = rf_addr_r1_q;
    rf_addr_r2_d = rf_addr_r2_q;
    rf_write_d   = 1'b0;
    rf_addr_w_d  = '0;
    rf_data_w_d  = '0;
    alu_op1_d    = alu_op1_q;
    alu_op2_d    = alu_op2_q;
    alu_oprn_d   = alu_oprn_q;
    done_d       = 1'b0;
    result_d     = result_q;
    zero_flag_d  = zero_flag_q;
    err_d        = 1'b0;

    case (state_q)
      S_IDLE: begin
        cmd_ready_d = 1'b1;
        if (CMD_VALID) begin
          cmd_d.oprn    = CMD_OPRN;
          cmd_d.rd      = CMD_RD;
          cmd_d.imm_sel = CMD_IMM_SEL;
          cmd_d.imm     = CMD_IMM;
          cmd_ready_d   = 1'b0;
          rf_read_d     = 1'b1;
          rf_addr_r1_d  = CMD_RS;
          rf_addr_r2_d  = CMD_RT;
          state_d       = S_FETCH;
        end
      end
      S_FETCH: begin
        alu_op1_d  = RF_DATA_R1;
        alu_op2_d  = cmd_q.imm_sel ? imm_ext_c : RF_DATA_R2;
        alu_oprn_d = cmd_q.oprn;
        state_d    = S_EXEC;
      end
      S_EXEC: begin
        // Illegal opcodes still complete, but publish a zeroed result
        result_d    = illegal_c ? '0 : ALU_OUT;
        zero_flag_d = illegal_c ? 1'b0 : ALU_ZERO;
        done_d      = 1'b1;
        err_d       = illegal_c;
        rf_write_d  = !illegal_c && (cmd_q.rd != '0);
        rf_addr_w_d = cmd_q.rd;
        rf_data_w_d = illegal_c ? '0 : ALU_OUT;
        state_d     = S_WB;
      end
      S_WB: begin
        cmd_ready_d = 1'b1;
        state_d     = S_IDLE;
      end
      default: begin
        cmd_ready_d = 1'b1;
        state_d     = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= S_IDLE;
      cmd_q        <= '0;
      cmd_ready_q  <= 1'b1;
      rf_read_q    <= 1'b0;
      rf_addr_r1_q <= '0;
      rf_addr_r2_q <= '0;
      rf_write_q   <= 1'b0;
      rf_addr_w_q  <= '0;
      rf_data_w_q  <= '0;
      alu_op1_q    <= '0;
      alu_op2_q    <= '0;
      alu_oprn_q   <= '0;
      done_q       <= 1'b0;
      result_q     <= '0;
      zero_flag_q  <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      cmd_ready_q  <= cmd_ready_d;
      rf_read_q    <= rf_read_d;
      rf_addr_r1_q <= rf_addr_r1_d;
      rf_addr_r2_q <= rf_addr_r2_d;
      rf_write_q   <= rf_write_d;
      rf_addr_w_q  <= rf_addr_w_d;
      rf_data_w_q  <= rf_data_w_d;
      alu_op1_q    <= alu_op1_d;
      alu_op2_q    <= alu_op2_d;
      alu_oprn_q   <= alu_oprn_d;
      done_q       <= done_d;
      result_q     <= result_d;
      zero_flag_q  <= zero_flag_d;
      err_q        <= err_d;
    end
  end

  assign CMD_READY  = cmd_ready_q;
  assign RF_READ    = rf_read_q;
  assign RF_ADDR_R1 = rf_addr_r1_q;
  assign RF_ADDR_R2 = rf_addr_r2_q;
  assign RF_WRITE   = rf_write_q;
  assign RF_ADDR_W  = rf_addr_w_q;
  assign RF_DATA_W  = rf_data_w_q;
  assign ALU_OP1    = alu_op1_q;
  assign ALU_OP2    = alu_op2_q;
  assign ALU_OPRN   = alu_oprn_q;
  assign DONE       = done_q;
  assign RESULT     = result_q;
  assign ZERO_FLAG  = zero_flag_q;
  assign ERR        = err_q;

endmodule

// File: tb/tb_alu_exec_sequencer.sv
// Directed bench for alu_exec_sequencer with a behavioural ALU and register file.
module tb_alu_exec_sequencer;

  logic        CLK, RST;
  logic        CMD_VALID, CMD_READY, CMD_IMM_SEL;
  logic [5:0]  CMD_OPRN;
  logic [4:0]  CMD_RS, CMD_RT, CMD_RD;
  logic [15:0] CMD_IMM;
  logic        RF_READ, RF_WRITE;
  logic [4:0]  RF_ADDR_R1, RF_ADDR_R2, RF_ADDR_W;
  logic [31:0] RF_DATA_R1, RF_DATA_R2, RF_DATA_W;
  logic [31:0] ALU_OP1, ALU_OP2, ALU_OUT, RESULT;
  logic [5:0]  ALU_OPRN;
  logic        ALU_ZERO, DONE, ZERO_FLAG, ERR;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int done_cnt = 0;
  int wr_cnt   = 0;
  logic [31:0] rf [32];

  alu_exec_sequencer dut (
    .CLK(CLK), .RST(RST),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_OPRN(CMD_OPRN),
    .CMD_RS(CMD_RS), .CMD_RT(CMD_RT), .CMD_RD(CMD_RD),
    .CMD_IMM_SEL(CMD_IMM_SEL), .CMD_IMM(CMD_IMM),
    .RF_READ(RF_READ), .RF_ADDR_R1(RF_ADDR_R1), .RF_ADDR_R2(RF_ADDR_R2),
    .RF_DATA_R1(RF_DATA_R1), .RF_DATA_R2(RF_DATA_R2),
    .RF_WRITE(RF_WRITE), .RF_ADDR_W(RF_ADDR_W), .RF_DATA_W(RF_DATA_W),
    .ALU_OP1(ALU_OP1), .ALU_OP2(ALU_OP2), .ALU_OPRN(ALU_OPRN),
    .ALU_OUT(ALU_OUT), .ALU_ZERO(ALU_ZERO),
    .DONE(DONE), .RESULT(RESULT), .ZERO_FLAG(ZERO_FLAG), .ERR(ERR)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  assign RF_DATA_R1 = rf[RF_ADDR_R1];
  assign RF_DATA_R2 = rf[RF_ADDR_R2];

  // Behavioural ALU; unknown opcodes yield a non-zero junk value
  always_comb begin
    case (ALU_OPRN)
      6'd1:    ALU_OUT = ALU_OP1 + ALU_OP2;
      6'd2:    ALU_OUT = ALU_OP1 - ALU_OP2;
      6'd3:    ALU_OUT = ALU_OP1 * ALU_OP2;
      6'd4:    ALU_OUT = ALU_OP1 >> ALU_OP2;
      6'd5:    ALU_OUT = ALU_OP1 << ALU_OP2;
      6'd6:    ALU_OUT = ALU_OP1 & ALU_OP2;
      6'd7:    ALU_OUT = ALU_OP1 | ALU_OP2;
      6'd8:    ALU_OUT = ~(ALU_OP1 | ALU_OP2);
      6'd9:    ALU_OUT = ($signed(ALU_OP1) < $signed(ALU_OP2)) ? 32'd1 : 32'd0;
      default: ALU_OUT = 32'hDEAD_BEEF;
    endcase
    ALU_ZERO = (ALU_OUT == 32'd0);
  end

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (DONE) done_cnt <= done_cnt + 1;
    if (RF_WRITE) begin
      wr_cnt <= wr_cnt + 1;
      rf[RF_ADDR_W] <= RF_DATA_W;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Runs one command from IDLE through WB back to IDLE, checking each phase
  task automatic run_cmd(input logic [5:0] oprn, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic imm_sel, input logic [15:0] imm,
                         input logic exp_wr, input logic [31:0] exp_res,
                         input logic exp_zero, input logic exp_err);
    check("idle_ready", 32'(CMD_READY), 32'd1);
    CMD_VALID = 1'b1; CMD_OPRN = oprn; CMD_RS = rs; CMD_RT = rt; CMD_RD = rd;
    CMD_IMM_SEL = imm_sel; CMD_IMM = imm;
    tick();
    CMD_VALID = 1'b0;
    check("fetch_ready", 32'(CMD_READY), 32'd0);
    check("fetch_read", 32'(RF_READ), 32'd1);
    check("fetch_addr_r1", 32'(RF_ADDR_R1), 32'(rs));
    check("fetch_no_write", 32'(RF_WRITE), 32'd0);
    tick();
    check("exec_ready", 32'(CMD_READY), 32'd0);
    check("exec_read", 32'(RF_READ), 32'd0);
    check("exec_oprn", 32'(ALU_OPRN), 32'(oprn));
    tick();
    check("wb_ready", 32'(CMD_READY), 32'd0);
    check("wb_done", 32'(DONE), 32'd1);
    check("wb_err", 32'(ERR), 32'(exp_err));
    check("wb_write", 32'(RF_WRITE), 32'(exp_wr));
    check("wb_read", 32'(RF_READ), 32'd0);
    if (exp_wr) begin
      check("wb_addr_w", 32'(RF_ADDR_W), 32'(rd));
      check("wb_data_w", RF_DATA_W, exp_res);
    end
    check("wb_result", RESULT, exp_res);
    check("wb_zero", 32'(ZERO_FLAG), 32'(exp_zero));
    tick();
    check("idle_done_low", 32'(DONE), 32'd0);
    check("idle_ready_back", 32'(CMD_READY), 32'd1);
    check("idle_oprn_hold", 32'(ALU_OPRN), 32'(oprn));
    check("idle_result_hold", RESULT, exp_res);
    if (exp_wr) check("rf_written", rf[rd], exp_res);
  endtask

  initial begin
    int wr_snap, done_snap, last_acc, wait_n;
    for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    rf[1] = 32'd15; rf[2] = 32'd3; rf[6] = 32'd10; rf[7] = 32'd5;
    RST = 1'b0; CMD_VALID = 1'b0; CMD_OPRN = '0; CMD_RS = '0; CMD_RT = '0; CMD_RD = '0;
    CMD_IMM_SEL = 1'b0; CMD_IMM = '0;
    #12;
    check("rst_ready", 32'(CMD_READY), 32'd1);
    check("rst_done", 32'(DONE), 32'd0);
    check("rst_result", RESULT, 32'd0);
    check("rst_alu_op1", ALU_OP1, 32'd0);
    check("rst_rf_read", 32'(RF_READ), 32'd0);
    #10 RST = 1'b1;
    tick();

    run_cmd(6'd1, 5'd1, 5'd2, 5'd3, 1'b0, 16'd0,     1'b1, 32'd18, 1'b0, 1'b0);
    run_cmd(6'd2, 5'd1, 5'd0, 5'd4, 1'b1, 16'd5,     1'b1, 32'd10, 1'b0, 1'b0);
    run_cmd(6'd1, 5'd1, 5'd0, 5'd4, 1'b1, 16'hFFFF,  1'b1, 32'd14, 1'b0, 1'b0);
    run_cmd(6'd9, 5'd6, 5'd7, 5'd5, 1'b0, 16'd0,     1'b1, 32'd0,  1'b1, 1'b0);
    run_cmd(6'd6, 5'd1, 5'd7, 5'd0, 1'b0, 16'd0,     1'b0, 32'd5,  1'b0, 1'b0);
    run_cmd(6'd3, 5'd1, 5'd2, 5'd10, 1'b0, 16'd0,    1'b1, 32'd45, 1'b0, 1'b0);
    run_cmd(6'd4, 5'd1, 5'd0, 5'd16, 1'b1, 16'd2,    1'b1, 32'd3,  1'b0, 1'b0);
    run_cmd(6'd8, 5'd1, 5'd2, 5'd17, 1'b0, 16'd0,    1'b1, 32'hFFFF_FFF0, 1'b0, 1'b0);
    run_cmd(6'h0A, 5'd1, 5'd2, 5'd3, 1'b0, 16'd0,    1'b0, 32'd0,  1'b0, 1'b1);
    check("illegal_no_clobber", rf[3], 32'd18);
    run_cmd(6'd1, 5'd1, 5'd2, 5'd9, 1'b0, 16'd0,     1'b1, 32'd18, 1'b0, 1'b0);
    run_cmd(6'd0, 5'd1, 5'd2, 5'd9, 1'b0, 16'd0,     1'b0, 32'd0,  1'b0, 1'b1);

    // Asynchronous reset while the command sits in EXEC
    wr_snap = wr_cnt;
    CMD_VALID = 1'b1; CMD_OPRN = 6'd1; CMD_RS = 5'd1; CMD_RT = 5'd2; CMD_RD = 5'd11;
    CMD_IMM_SEL = 1'b0;
    tick();
    CMD_VALID = 1'b0;
    tick();
    check("pre_rst_op1", ALU_OP1, 32'd15);
    #2 RST = 1'b0;
    #1;
    check("arst_ready", 32'(CMD_READY), 32'd1);
    check("arst_op1", ALU_OP1, 32'd0);
    check("arst_oprn", 32'(ALU_OPRN), 32'd0);
    check("arst_result", RESULT, 32'd0);
    check("arst_done", 32'(DONE), 32'd0);
    @(negedge CLK) RST = 1'b1;
    repeat (5) tick();
    check("arst_no_write", 32'(wr_cnt - wr_snap), 32'd0);
    check("arst_rf11", rf[11], 32'd0);
    check("arst_idle_ready", 32'(CMD_READY), 32'd1);

    // Three commands queued with CMD_VALID held high
    done_snap = done_cnt;
    last_acc  = -1;
    CMD_IMM_SEL = 1'b0;
    CMD_RS = 5'd1; CMD_RT = 5'd2;
    for (int k = 0; k < 3; k++) begin
      wait_n = 0;
      while (!CMD_READY && wait_n < 10) begin
        tick();
        wait_n++;
      end
      check("b2b_ready_timeout", 32'(CMD_READY), 32'd1);
      CMD_VALID = 1'b1;
      CMD_RD = 5'(13 + k);
      CMD_OPRN = (k == 0) ? 6'd1 : (k == 1) ? 6'd2 : 6'd7;
      tick();
      if (last_acc >= 0) check("b2b_spacing", 32'(cyc - last_acc), 32'd4);
      last_acc = cyc;
      if (k == 2) CMD_VALID = 1'b0;
    end
    repeat (5) tick();
    check("b2b_done_pulses", 32'(done_cnt - done_snap), 32'd3);
    check("b2b_rf13", rf[13], 32'd18);
    check("b2b_rf14", rf[14], 32'd12);
    check("b2b_rf15", rf[15], 32'd15);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
